// File: rtl/tpu_apb_cfg_sequencer.sv
// Replays a table of APB register writes, then polls a status register until it reports done or the poll budget runs out.
// Each transfer takes 2 clocks plus PREADY wait states; the block stalls in ACCESS for as long as PREADY stays low.
module tpu_apb_cfg_sequencer #(
  parameter int                       REG_ADDRWIDTH = 8,
  parameter int                       REG_DATAWIDTH = 32,
  parameter int                       NUM_ENTRIES   = 8,
  parameter logic [REG_ADDRWIDTH-1:0] STATUS_ADDR   = REG_ADDRWIDTH'('h04),
  parameter logic [REG_DATAWIDTH-1:0] DONE_MASK     = REG_DATAWIDTH'('h1),
  parameter int                       POLL_LIMIT    = 16,
  localparam int                      IDXW          = $clog2(NUM_ENTRIES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tbl_we,
  input  logic [IDXW-1:0]          tbl_idx,
  input  logic [REG_ADDRWIDTH-1:0] tbl_addr,
  input  logic [REG_DATAWIDTH-1:0] tbl_data,
  input  logic [IDXW:0]            num_writes,
  input  logic                     start,
  output logic [REG_ADDRWIDTH-1:0] PADDR,
  output logic                     PWRITE,
  output logic                     PSEL,
  output logic                     PENABLE,
  output logic [REG_DATAWIDTH-1:0] PWDATA,
  input  logic [REG_DATAWIDTH-1:0] PRDATA,
  input  logic                     PREADY,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [REG_DATAWIDTH-1:0] status_q
);

  localparam int CW = IDXW + 1;
  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_SETUP,
    WR_ACCESS,
    RD_SETUP,
    RD_ACCESS,
    FINISH
  } state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            ptr_q, ptr_d, cnt_q, cnt_d, ptr_inc;
  logic [PW-1:0]            poll_q, poll_d, poll_inc;
  logic [REG_DATAWIDTH-1:0] status_d;
  logic                     psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [REG_ADDRWIDTH-1:0] paddr_q, paddr_d;
  logic [REG_DATAWIDTH-1:0] pwdata_q, pwdata_d;
  logic                     busy_q, busy_d, done_q, done_d, timeout_q, timeout_d;

  logic [REG_ADDRWIDTH-1:0] tbl_addr_mem [NUM_ENTRIES];
  logic [REG_DATAWIDTH-1:0] tbl_data_mem [NUM_ENTRIES];
  logic                     tbl_wr;
  logic [IDXW-1:0]          ent_idx;
  logic [REG_ADDRWIDTH-1:0] ent_addr;
  logic [REG_DATAWIDTH-1:0] ent_data;

  assign tbl_wr   = tbl_we && (state_q == IDLE);
  assign ptr_inc  = ptr_q + CW'(1);
  assign poll_inc = poll_q + PW'(1);

  // The table holds no reset; it is only meaningful once software has loaded it.
  always_ff @(posedge clk) begin
    if (tbl_wr) begin
      tbl_addr_mem[tbl_idx] <= tbl_addr;
      tbl_data_mem[tbl_idx] <= tbl_data;
    end
  end

  // Bypass covers a table write landing on the same edge that launches entry 0.
  assign ent_idx  = ptr_d[IDXW-1:0];
  assign ent_addr = (tbl_wr && tbl_idx == ent_idx) ? tbl_addr : tbl_addr_mem[ent_idx];
  assign ent_data = (tbl_wr && tbl_idx == ent_idx) ? tbl_data : tbl_data_mem[ent_idx];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    poll_d    = poll_q;
    status_d  = status_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = num_writes;
          ptr_d   = '0;
          poll_d  = '0;
          state_d = (num_writes != '0) ? WR_SETUP : RD_SETUP;
        end
      end
      WR_SETUP: state_d = WR_ACCESS;
      WR_ACCESS: begin
        if (PREADY) begin
          ptr_d   = ptr_inc;
          state_d = (ptr_inc == cnt_q) ? RD_SETUP : WR_SETUP;
        end
      end
      RD_SETUP: state_d = RD_ACCESS;
      RD_ACCESS: begin
        if (PREADY) begin
          status_d = PRDATA;
          poll_d   = poll_inc;
          if (|(PRDATA & DONE_MASK)) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else if (poll_inc == PW'(POLL_LIMIT)) begin
            state_d   = FINISH;
            timeout_d = 1'b1;
          end else begin
            state_d = RD_SETUP;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered off the next state so they line up with the state they describe.
    psel_d    = 1'b0;
    penable_d = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = '0;
    pwdata_d  = '0;
    case (state_d)
      WR_SETUP, WR_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == WR_ACCESS);
        pwrite_d  = 1'b1;
        paddr_d   = ent_addr;
        pwdata_d  = ent_data;
      end
      RD_SETUP, RD_ACCESS: begin
        psel_d    = 1'b1;
        penable_d = (state_d == RD_ACCESS);
        paddr_d   = STATUS_ADDR;
      end
      default: ;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      poll_q    <= '0;
      status_q  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      poll_q    <= poll_d;
      status_q  <= status_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PWRITE  = pwrite_q;
  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign timeout = timeout_q;

endmodule
